game_sequencer: RTL and testbench

- Top-level rhythm-game controller for the LED matrix note highway.
- Sequences the note shifter: start, countdown, play, result.
- Latches the song selection and gates shifter advance.
- Judges red/blue button presses against the notes in the judgment column, and keeps score, combo and last-judgment state for display logic.

---
 rtl/game_pkg.sv | 25 ++
 rtl/hit_judge.sv | 44 ++++
 rtl/game_sequencer.sv | 155 +++++++++++++++
 tb/tb_game_sequencer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared encodings for the rhythm-game sequencer: FSM states, judgment codes, combo width.
package game_pkg;

  localparam int COMBO_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_PLAY      = 2'd2,
    ST_RESULT    = 2'd3
  } state_t;

  // Codes are ordered by severity so the worst result is simply the larger code.
  typedef enum logic [1:0] {
    J_NONE  = 2'd0,
    J_GREAT = 2'd1,
    J_GOOD  = 2'd2,
    J_MISS  = 2'd3
  } judge_t;

  function automatic judge_t worst(input judge_t a, input judge_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hit_judge.sv
// Per-colour judgment: tracks the note waiting in the judgment column and
// classifies button presses against it as GREAT, GOOD or MISS.
module hit_judge
  import game_pkg::*;
#(
  parameter int GREAT_OFS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       press,
  input  logic       tick,
  input  logic       head,
  input  logic [2:0] offset,
  input  logic       en,
  input  logic       flush,
  output logic       hit_great,
  output logic       hit_good,
  output logic       miss
);

  localparam logic [2:0] GREAT_LIM = 3'(GREAT_OFS);

  logic pending;
  logic hit;

  // A press resolves the old note before a same-cycle tick loads the next one.
  assign hit       = en & press & pending;
  assign hit_great = hit & (offset <= GREAT_LIM);
  assign hit_good  = hit & (offset > GREAT_LIM);
  assign miss      = en & (tick | flush) & pending & ~hit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending <= 1'b0;
    end else if (flush) begin
      pending <= 1'b0;
    end else if (en && tick) begin
      pending <= head;
    end else if (hit) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Rhythm-game controller: sequences the note shifter and keeps score, combo
// and last-judgment state for the display.
//
//   state        | meaning
//   ST_IDLE      | waiting for start press
//   ST_COUNTDOWN | shifter cleared, counting COUNT_TICKS shift ticks
//   ST_PLAY      | shifter running, button presses judged
//   ST_RESULT    | song over, results frozen until start press
module game_sequencer
  import game_pkg::*;
#(
  parameter int COUNT_TICKS = 16,
  parameter int GREAT_OFS   = 2,
  parameter int SCORE_GREAT = 3,
  parameter int SCORE_GOOD  = 1,
  parameter int SCORE_W     = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [2:0]         offset,
  input  logic               finish,
  input  logic               head_R,
  input  logic               head_B,
  input  logic               start_btn,
  input  logic               red_btn,
  input  logic               blue_btn,
  input  logic [1:0]         song_sw,
  output logic               shift_en,
  output logic               shift_rst,
  output logic [1:0]         song_sel,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [COMBO_W-1:0] combo,
  output logic [COMBO_W-1:0] max_combo,
  output logic [1:0]         judge
);

  localparam int              CD_W       = $clog2(COUNT_TICKS + 2);
  localparam logic [CD_W-1:0] CD_INIT    = CD_W'(COUNT_TICKS);
  localparam logic [SCORE_W:0] PTS_GREAT = (SCORE_W + 1)'(SCORE_GREAT);
  localparam logic [SCORE_W:0] PTS_GOOD  = (SCORE_W + 1)'(SCORE_GOOD);

  state_t          st_q;
  judge_t          judge_q;
  logic [CD_W-1:0] countdown;
  logic            start_q, red_q, blue_q;
  logic            start_p, red_p, blue_p;
  logic            play, flush;
  logic            great_r, good_r, miss_r, great_b, good_b, miss_b;

  logic [1:0]         hits;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_nx;
  logic [COMBO_W:0]   combo_sum;
  logic [COMBO_W-1:0] combo_nx, max_nx;
  judge_t             judge_ev;

  assign start_p = start_btn & ~start_q;
  assign red_p   = red_btn & ~red_q;
  assign blue_p  = blue_btn & ~blue_q;
  assign play    = (st_q == ST_PLAY);
  // Pending notes are dropped both when a new song starts and when the song ends.
  assign flush   = ((st_q == ST_IDLE) & start_p) | (play & finish);
  assign state   = st_q;
  assign judge   = judge_q;

  hit_judge #(.GREAT_OFS(GREAT_OFS)) u_judge_r (
    .clk(clk), .rst(rst), .press(red_p), .tick(tick), .head(head_R), .offset(offset),
    .en(play), .flush(flush), .hit_great(great_r), .hit_good(good_r), .miss(miss_r)
  );

  hit_judge #(.GREAT_OFS(GREAT_OFS)) u_judge_b (
    .clk(clk), .rst(rst), .press(blue_p), .tick(tick), .head(head_B), .offset(offset),
    .en(play), .flush(flush), .hit_great(great_b), .hit_good(good_b), .miss(miss_b)
  );

  always_comb begin
    hits      = {1'b0, great_r | good_r} + {1'b0, great_b | good_b};
    score_sum = {1'b0, score}
              + ({(SCORE_W + 1){great_r}} & PTS_GREAT) + ({(SCORE_W + 1){great_b}} & PTS_GREAT)
              + ({(SCORE_W + 1){good_r}} & PTS_GOOD) + ({(SCORE_W + 1){good_b}} & PTS_GOOD);
    score_nx  = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    combo_sum = ((miss_r | miss_b) ? '0 : {1'b0, combo}) + (COMBO_W + 1)'(hits);
    combo_nx  = combo_sum[COMBO_W] ? '1 : combo_sum[COMBO_W-1:0];
    max_nx    = (combo_nx > max_combo) ? combo_nx : max_combo;
    judge_ev  = J_NONE;
    if (great_r | great_b) judge_ev = worst(judge_ev, J_GREAT);
    if (good_r | good_b)   judge_ev = worst(judge_ev, J_GOOD);
    if (miss_r | miss_b)   judge_ev = worst(judge_ev, J_MISS);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q      <= ST_IDLE;
      shift_en  <= 1'b0;
      shift_rst <= 1'b1;
      song_sel  <= 2'd0;
      score     <= '0;
      combo     <= '0;
      max_combo <= '0;
      judge_q   <= J_NONE;
      countdown <= '0;
      start_q   <= 1'b0;
      red_q     <= 1'b0;
      blue_q    <= 1'b0;
    end else begin
      start_q   <= start_btn;
      red_q     <= red_btn;
      blue_q    <= blue_btn;
      shift_rst <= 1'b1;
      case (st_q)
        ST_IDLE: begin
          if (start_p) begin
            st_q      <= ST_COUNTDOWN;
            song_sel  <= song_sw;
            score     <= '0;
            combo     <= '0;
            max_combo <= '0;
            judge_q   <= J_NONE;
            shift_rst <= 1'b0;
            countdown <= CD_INIT;
          end
        end
        ST_COUNTDOWN: begin
          if (countdown == '0) begin
            st_q     <= ST_PLAY;
            shift_en <= 1'b1;
          end else if (tick) begin
            countdown <= countdown - 1'b1;
            if (countdown == CD_W'(1)) begin
              st_q     <= ST_PLAY;
              shift_en <= 1'b1;
            end
          end
        end
        ST_PLAY: begin
          score     <= score_nx;
          combo     <= combo_nx;
          max_combo <= max_nx;
          if (judge_ev != J_NONE) judge_q <= judge_ev;
          if (finish) begin
            st_q     <= ST_RESULT;
            shift_en <= 1'b0;
          end
        end
        ST_RESULT: begin
          if (start_p) st_q <= ST_IDLE;
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: each stimulus cycle queues its hand-computed
// expected outputs, and a monitor compares them after the following clock edge.
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        rst, tick, finish, head_R, head_B, start_btn, red_btn, blue_btn;
  logic [2:0]  offset;
  logic [1:0]  song_sw;
  logic        shift_en, shift_rst;
  logic [1:0]  song_sel, state, judge;
  logic [13:0] score;
  logic [7:0]  combo, max_combo;

  typedef struct {
    bit          chk;
    string       nm;
    logic [1:0]  st;
    logic        en;
    logic        srst;
    logic [1:0]  sel;
    logic [13:0] sc;
    logic [7:0]  cb;
    logic [7:0]  mx;
    logic [1:0]  jd;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [1:0]  x_st, x_sel, x_jd;
  logic        x_en, x_srst;
  logic [13:0] x_sc;
  logic [7:0]  x_cb, x_mx;

  game_sequencer dut (
    .clk(clk), .rst(rst), .tick(tick), .offset(offset), .finish(finish),
    .head_R(head_R), .head_B(head_B), .start_btn(start_btn), .red_btn(red_btn),
    .blue_btn(blue_btn), .song_sw(song_sw), .shift_en(shift_en), .shift_rst(shift_rst),
    .song_sel(song_sel), .state(state), .score(score), .combo(combo),
    .max_combo(max_combo), .judge(judge)
  );

  always #5 clk = ~clk;

  task automatic x(input logic [1:0] st, input logic en, input logic srst, input logic [1:0] sel,
                   input logic [13:0] sc, input logic [7:0] cb, input logic [7:0] mx,
                   input logic [1:0] jd);
    x_st = st; x_en = en; x_srst = srst; x_sel = sel;
    x_sc = sc; x_cb = cb; x_mx = mx; x_jd = jd;
  endtask

  // One clock cycle with the inputs currently driven; pulses and buttons drop afterwards.
  task automatic cyc(input string nm, input bit chk);
    exp_t e;
    e.chk = chk; e.nm = nm; e.st = x_st; e.en = x_en; e.srst = x_srst; e.sel = x_sel;
    e.sc = x_sc; e.cb = x_cb; e.mx = x_mx; e.jd = x_jd;
    q.push_back(e);
    @(negedge clk);
    rst = 1'b1; tick = 1'b0; finish = 1'b0;
    start_btn = 1'b0; red_btn = 1'b0; blue_btn = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) begin
          n_vec++;
          if (state !== e.st || shift_en !== e.en || shift_rst !== e.srst || song_sel !== e.sel ||
              score !== e.sc || combo !== e.cb || max_combo !== e.mx || judge !== e.jd) begin
            n_err++;
            $display("FAIL %s: got st=%0d en=%0d srst=%0d sel=%0d score=%0d combo=%0d max=%0d judge=%0d; want st=%0d en=%0d srst=%0d sel=%0d score=%0d combo=%0d max=%0d judge=%0d",
                     e.nm, state, shift_en, shift_rst, song_sel, score, combo, max_combo, judge,
                     e.st, e.en, e.srst, e.sel, e.sc, e.cb, e.mx, e.jd);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: bench still running at time %0t, required to finish earlier", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int sc, cb;
    rst = 1'b0; tick = 1'b0; finish = 1'b0; head_R = 1'b0; head_B = 1'b0;
    start_btn = 1'b0; red_btn = 1'b0; blue_btn = 1'b0; offset = 3'd0; song_sw = 2'd0;
    x(0, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);

    rst = 1'b0; cyc("reset", 1);
    tick = 1'b1; red_btn = 1'b1; cyc("idle_hold", 1);

    song_sw = 2'd2; start_btn = 1'b1; x(1, 0, 0, 2, 0, 0, 0, 0); cyc("start", 1);
    song_sw = 2'd1; x(1, 0, 1, 2, 0, 0, 0, 0); cyc("srst_pulse", 1);
    start_btn = 1'b1; cyc("start_ignored_cd", 1);
    for (int i = 0; i < 15; i++) begin
      tick = 1'b1; cyc("countdown", 1);
    end
    tick = 1'b1; x(2, 1, 1, 2, 0, 0, 0, 0); cyc("play_entry", 1);

    tick = 1'b1; head_R = 1'b1; cyc("load_R", 1);
    head_R = 1'b0; red_btn = 1'b1; offset = 3'd1; x(2, 1, 1, 2, 3, 1, 1, 1); cyc("great_R", 1);
    offset = 3'd0; tick = 1'b1; head_B = 1'b1; cyc("no_miss", 1);
    head_B = 1'b0; tick = 1'b1; x(2, 1, 1, 2, 3, 0, 1, 3); cyc("miss_B", 1);
    tick = 1'b1; head_R = 1'b1; head_B = 1'b1; cyc("load_RB", 1);
    head_R = 1'b0; head_B = 1'b0; red_btn = 1'b1; blue_btn = 1'b1; offset = 3'd5;
    x(2, 1, 1, 2, 5, 2, 2, 2); cyc("good_RB", 1);
    offset = 3'd0; cyc("idle_play", 1);
    red_btn = 1'b1; cyc("ignored_press", 1);
    tick = 1'b1; head_R = 1'b1; cyc("load_R2", 1);
    head_R = 1'b0; red_btn = 1'b1; offset = 3'd2; x(2, 1, 1, 2, 8, 3, 3, 1); cyc("great_edge", 1);
    offset = 3'd0; tick = 1'b1; head_R = 1'b1; cyc("load_R3", 1);
    head_R = 1'b0; red_btn = 1'b1; offset = 3'd3; x(2, 1, 1, 2, 9, 4, 4, 2); cyc("good_edge", 1);
    offset = 3'd0; tick = 1'b1; head_R = 1'b1; cyc("load_R4", 1);
    tick = 1'b1; head_R = 1'b1; red_btn = 1'b1; x(2, 1, 1, 2, 12, 5, 5, 1); cyc("press_tick", 1);
    tick = 1'b1; head_R = 1'b0; x(2, 1, 1, 2, 12, 0, 5, 3); cyc("miss_reloaded", 1);
    tick = 1'b1; head_R = 1'b1; head_B = 1'b1; cyc("load_RB2", 1);
    head_R = 1'b0; head_B = 1'b0; blue_btn = 1'b1; x(2, 1, 1, 2, 15, 1, 5, 1); cyc("great_B", 1);
    finish = 1'b1; x(3, 0, 1, 2, 15, 0, 5, 3); cyc("finish_miss", 1);
    tick = 1'b1; red_btn = 1'b1; blue_btn = 1'b1; head_R = 1'b1; cyc("result_frozen", 1);
    head_R = 1'b0; start_btn = 1'b1; x(0, 0, 1, 2, 15, 0, 5, 3); cyc("result_to_idle", 1);
    cyc("idle_again", 1);

    song_sw = 2'd3; start_btn = 1'b1; x(1, 0, 0, 3, 0, 0, 0, 0); cyc("restart_clear", 1);
    x(1, 0, 1, 3, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      tick = 1'b1; cyc("countdown2", 1);
    end
    tick = 1'b1; x(2, 1, 1, 3, 0, 0, 0, 0); cyc("play_entry2", 1);
    tick = 1'b1; head_R = 1'b1; cyc("load_sat", 1);
    // Every iteration hits the pending note and reloads it; combo and score run into saturation.
    for (int n = 1; n <= 5463; n++) begin
      sc = (n * 3 > 16383) ? 16383 : n * 3;
      cb = (n > 255) ? 255 : n;
      tick = 1'b1; head_R = 1'b1; red_btn = 1'b1;
      x(2, 1, 1, 3, 14'(sc), 8'(cb), 8'(cb), 1);
      cyc("sat_hit", 1);
      cyc("sat_gap", 1);
    end

    rst = 1'b0; tick = 1'b1; x(0, 0, 1, 0, 0, 0, 0, 0); cyc("mid_reset", 1);
    tick = 1'b1; head_R = 1'b0; cyc("post_reset", 1);

    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
